// File: rtl/mem_burst_responder.sv
// Block-request memory responder: fixed latency, critical-word-first wrapped burst.
// Optional MEM_RESP_ACK_EN adds o_mem_req_ack, a one-cycle pulse after each acceptance.
module mem_burst_responder #(
  parameter int MEM_IF_ADDR    = 16,
  parameter int MEM_IF_DATA    = 32,
  parameter int BURST_LEN      = 4,
  parameter int MEM_DEPTH_LOG2 = 8,
  parameter int LATENCY        = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [MEM_IF_ADDR-1:0]    i_mem_req_addr,
  input  logic                      i_mem_req_valid,
  output logic                      o_mem_ready,
  output logic [MEM_IF_DATA-1:0]    o_mem_data,
  output logic                      o_mem_data_valid,
  output logic                      o_mem_data_last,
  input  logic                      i_halt,
  input  logic                      i_wr_en,
  input  logic [MEM_DEPTH_LOG2-1:0] i_wr_addr,
  input  logic [MEM_IF_DATA-1:0]    i_wr_data
`ifdef MEM_RESP_ACK_EN
  ,
  output logic                      o_mem_req_ack
`endif
);

  localparam int OFFW = $clog2(BURST_LEN);
  localparam logic [OFFW-1:0] LAST_BEAT = OFFW'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BURST
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [MEM_IF_ADDR-1:0]   addr_q;
  logic [3:0]               lat_cnt;
  logic [OFFW-1:0]          beat_cnt;
  logic [OFFW-1:0]          beat_nxt;
  logic                     ready;
  logic                     accept;
  logic                     lat_done;
  logic [MEM_IF_DATA-1:0]   data_q;
  logic                     valid_q;
  logic                     last_q;
  logic [MEM_IF_DATA-1:0]   mem [2**MEM_DEPTH_LOG2];

  // Wrap within the block: only the low OFFW bits advance.
  function automatic logic [MEM_DEPTH_LOG2-1:0] beat_idx(
    input logic [MEM_IF_ADDR-1:0] a,
    input logic [OFFW-1:0]        k
  );
    logic [MEM_IF_ADDR-1:0] w;
    w = a;
    w[OFFW-1:0] = a[OFFW-1:0] + k;
    return w[MEM_DEPTH_LOG2-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept) state_nxt = (LATENCY == 1) ? S_BURST : S_WAIT;
      S_WAIT:  if (lat_done) state_nxt = S_BURST;
      S_BURST: if (!i_halt && beat_cnt == LAST_BEAT) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ready    = 1'b0;
    lat_done = 1'b0;
    unique case (state)
      S_IDLE:  ready = ~rst;
      S_WAIT:  lat_done = (lat_cnt == 4'd1);
      default: ;
    endcase
    accept = ready & i_mem_req_valid;
  end

  assign beat_nxt = beat_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      lat_cnt  <= '0;
      beat_cnt <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (accept) begin
          addr_q   <= i_mem_req_addr;
          lat_cnt  <= 4'(LATENCY - 1);
          beat_cnt <= '0;
          if (LATENCY == 1) begin
            data_q  <= mem[beat_idx(i_mem_req_addr, '0)];
            valid_q <= 1'b1;
            last_q  <= 1'b0;
          end
        end
        S_WAIT: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_done) begin
            data_q  <= mem[beat_idx(addr_q, '0)];
            valid_q <= 1'b1;
            last_q  <= 1'b0;
          end
        end
        S_BURST: if (!i_halt) begin
          if (beat_cnt != LAST_BEAT) begin
            data_q   <= mem[beat_idx(addr_q, beat_nxt)];
            beat_cnt <= beat_nxt;
            last_q   <= (beat_nxt == LAST_BEAT);
          end else begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Array is never cleared; reads above see pre-write contents on a same-edge write.
  always_ff @(posedge clk) begin
    if (!rst && i_wr_en) mem[i_wr_addr] <= i_wr_data;
  end

`ifdef MEM_RESP_ACK_EN
  always_ff @(posedge clk) begin
    if (rst) o_mem_req_ack <= 1'b0;
    else     o_mem_req_ack <= accept;
  end
`endif

  assign o_mem_ready      = ready;
  assign o_mem_data       = data_q;
  assign o_mem_data_valid = valid_q;
  assign o_mem_data_last  = last_q;

endmodule
